// File: rtl/seq_detect_moore_param_pkg.sv
// Shared definitions for the parametrised Moore pattern detector: limits,
// state width and the KMP fallback used to build the transition ROM.
package seq_detect_moore_param_pkg;

  localparam int unsigned PAT_LEN_MIN = 2;
  localparam int unsigned PAT_LEN_MAX = 16;
  localparam int unsigned IDX_W       = 4;

  function automatic int unsigned state_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (first s pattern bits + b);
  // k is capped at len so that a full-pattern state can rematch on overlap.
  function automatic int unsigned next_prefix(
    input logic [PAT_LEN_MAX-1:0] pattern,
    input int unsigned            len,
    input int unsigned            s,
    input logic                   b
  );
    int unsigned best;
    int unsigned kmax;
    int unsigned j;
    logic        ok;
    logic        tj;
    best = 0;
    kmax = ((s + 1) < len) ? (s + 1) : len;
    for (int unsigned k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < k; i++) begin
        j  = s + 1 - k + i;
        tj = (j < s) ? pattern[IDX_W'(len - 1 - j)] : b;
        if (pattern[IDX_W'(len - 1 - i)] != tj) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial-pattern detector with valid qualifier, restart
// and saturating match counter. State equals the matched-prefix length.
module seq_detect_moore_param
  import seq_detect_moore_param_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic                         clk_pulse,
  input  logic                         clear,
  input  logic                         inp_valid,
  input  logic                         inp_1,
  input  logic                         restart,
  input  logic                         cnt_clr,
  output logic                         out,
  output logic [$clog2(PAT_LEN+1)-1:0] present_state,
  output logic [CNT_W-1:0]             match_count
);

  localparam int unsigned SW = state_w(PAT_LEN);
  localparam logic [PAT_LEN_MAX-1:0] PAT_EXT = PAT_LEN_MAX'(PATTERN);
  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_len
    $error("seq_detect_moore_param: PAT_LEN must be within 2..16");
  end

  // Transition ROM indexed by {state, bit}; non-overlap mode restarts from the empty prefix.
  logic [(PAT_LEN+1)*2-1:0][SW-1:0] trans_rom;

  for (genvar s = 0; s <= PAT_LEN; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int unsigned SRC = ((s == PAT_LEN) && !OVERLAP) ? 0 : s;
      localparam int unsigned NXT = next_prefix(PAT_EXT, PAT_LEN, SRC, 1'(b));
      assign trans_rom[s*2+b] = SW'(NXT);
    end
  end

  logic [SW-1:0] rom_next_c;
  logic [SW-1:0] next_state_c;
  logic          match_inc_c;

  always_comb begin
    rom_next_c   = trans_rom[{present_state, inp_1}];
    next_state_c = present_state;
    match_inc_c  = 1'b0;
    if (restart) begin
      next_state_c = '0;
    end else if (inp_valid) begin
      next_state_c = rom_next_c;
      match_inc_c  = (rom_next_c == FULL);
    end
  end

  always_ff @(posedge clk_pulse or negedge clear) begin
    if (!clear) begin
      present_state <= '0;
      out           <= 1'b0;
    end else begin
      present_state <= next_state_c;
      out           <= (next_state_c == FULL);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk_pulse),
    .rst_n (clear),
    .inc   (match_inc_c),
    .clr   (cnt_clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed bench for seq_detect_moore_param: three instances (overlap,
// non-overlap, 2-bit counter) share one stimulus stream.
module tb_seq_detect_moore_param;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic inp_valid = 1'b0;
  logic inp_1 = 1'b0;
  logic restart = 1'b0;
  logic cnt_clr = 1'b0;

  logic       ov_out, no_out, sat_out;
  logic [2:0] ov_state, no_state, sat_state;
  logic [7:0] ov_cnt, no_cnt;
  logic [1:0] sat_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detect_moore_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk_pulse(clk), .clear(clear), .inp_valid(inp_valid), .inp_1(inp_1),
    .restart(restart), .cnt_clr(cnt_clr), .out(ov_out),
    .present_state(ov_state), .match_count(ov_cnt));

  seq_detect_moore_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk_pulse(clk), .clear(clear), .inp_valid(inp_valid), .inp_1(inp_1),
    .restart(restart), .cnt_clr(cnt_clr), .out(no_out),
    .present_state(no_state), .match_count(no_cnt));

  seq_detect_moore_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk_pulse(clk), .clear(clear), .inp_valid(inp_valid), .inp_1(inp_1),
    .restart(restart), .cnt_clr(cnt_clr), .out(sat_out),
    .present_state(sat_state), .match_count(sat_cnt));

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic send(input logic b, input logic v, input logic rs, input logic cc);
    inp_valid = v;
    inp_1     = b;
    restart   = rs;
    cnt_clr   = cc;
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    restart   = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    #3;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] bits;
    bits = 7'b1101110;
    do_reset();
    tests++;
    if (ov_state !== 3'd0 || ov_out !== 1'b0 || ov_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_init: state=%0d out=%b cnt=%0d, want 0/0/0", ov_state, ov_out, ov_cnt);
    end
    for (int i = 6; i >= 0; i--) send(bits[i], 1'b1, 1'b0, 1'b0);
    tests++;
    if (ov_state !== 3'd3 || ov_cnt !== 8'd1) begin
      fails++;
      $display("FAIL reset_pre: state=%0d cnt=%0d, want 3/1", ov_state, ov_cnt);
    end
    #2;
    clear = 1'b0;
    #1;
    tests++;
    if (ov_state !== 3'd0 || ov_out !== 1'b0 || ov_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_async: state=%0d out=%b cnt=%0d, want 0/0/0", ov_state, ov_out, ov_cnt);
    end
    #1;
    clear = 1'b1;
  endtask

  task automatic test_overlap();
    logic [7:0] bits;
    int exp_state [8] = '{1, 2, 3, 4, 5, 3, 4, 5};
    bits = 8'b11011011;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(bits[7-i], 1'b1, 1'b0, 1'b0);
      tests++;
      if (ov_state !== 3'(exp_state[i]) || ov_out !== (exp_state[i] == 5)) begin
        fails++;
        $display("FAIL overlap_bit%0d: state=%0d out=%b, want %0d/%b",
                 i + 1, ov_state, ov_out, exp_state[i], exp_state[i] == 5);
      end
    end
    tests++;
    if (ov_cnt !== 8'd2) begin
      fails++;
      $display("FAIL overlap_count: cnt=%0d, want 2", ov_cnt);
    end
  endtask

  task automatic test_no_overlap();
    logic [10:0] bits;
    int exp_state [11] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    bits = 11'b11011011011;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(bits[10-i], 1'b1, 1'b0, 1'b0);
      tests++;
      if (no_state !== 3'(exp_state[i]) || no_out !== (exp_state[i] == 5)) begin
        fails++;
        $display("FAIL nooverlap_bit%0d: state=%0d out=%b, want %0d/%b",
                 i + 1, no_state, no_out, exp_state[i], exp_state[i] == 5);
      end
    end
    tests++;
    if (no_cnt !== 8'd2) begin
      fails++;
      $display("FAIL nooverlap_count: cnt=%0d, want 2", no_cnt);
    end
  endtask

  task automatic test_stall();
    logic [3:0] bits;
    bits = 4'b1101;
    do_reset();
    for (int i = 3; i >= 0; i--) send(bits[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'(i), 1'b0, 1'b0, 1'b0);
      tests++;
      if (ov_state !== 3'd4 || ov_out !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: state=%0d out=%b, want 4/0", i, ov_state, ov_out);
      end
    end
    send(1'b1, 1'b1, 1'b0, 1'b0);
    tests++;
    if (ov_state !== 3'd5 || ov_out !== 1'b1 || ov_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stall_match: state=%0d out=%b cnt=%0d, want 5/1/1", ov_state, ov_out, ov_cnt);
    end
    send(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (ov_state !== 3'd5 || ov_out !== 1'b1 || ov_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stall_full: state=%0d out=%b cnt=%0d, want 5/1/1", ov_state, ov_out, ov_cnt);
    end
  endtask

  task automatic test_restart();
    logic [6:0] bits;
    bits = 7'b1101101;
    do_reset();
    for (int i = 6; i >= 0; i--) send(bits[i], 1'b1, 1'b0, 1'b0);
    tests++;
    if (ov_state !== 3'd4 || ov_cnt !== 8'd1) begin
      fails++;
      $display("FAIL restart_pre: state=%0d cnt=%0d, want 4/1", ov_state, ov_cnt);
    end
    send(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (ov_state !== 3'd0 || ov_out !== 1'b0 || ov_cnt !== 8'd1) begin
      fails++;
      $display("FAIL restart_win: state=%0d out=%b cnt=%0d, want 0/0/1", ov_state, ov_out, ov_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [4:0] first;
    logic [2:0] tail;
    first = 5'b11011;
    tail  = 3'b011;
    do_reset();
    for (int i = 4; i >= 0; i--) send(first[i], 1'b1, 1'b0, 1'b0);
    tests++;
    if (sat_cnt !== 2'd1 || sat_out !== 1'b1) begin
      fails++;
      $display("FAIL sat_match1: cnt=%0d out=%b, want 1/1", sat_cnt, sat_out);
    end
    for (int m = 2; m <= 5; m++) begin
      for (int i = 2; i >= 0; i--) send(tail[i], 1'b1, 1'b0, 1'b0);
      tests++;
      if (sat_cnt !== 2'((m > 3) ? 3 : m) || sat_out !== 1'b1) begin
        fails++;
        $display("FAIL sat_match%0d: cnt=%0d out=%b, want %0d/1",
                 m, sat_cnt, sat_out, (m > 3) ? 3 : m);
      end
    end
    tests++;
    if (ov_cnt !== 8'd5) begin
      fails++;
      $display("FAIL sat_wide_count: cnt=%0d, want 5", ov_cnt);
    end
    send(1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    tests++;
    if (sat_cnt !== 2'd0 || sat_out !== 1'b1 || ov_cnt !== 8'd0) begin
      fails++;
      $display("FAIL cntclr_wins: sat_cnt=%0d out=%b ov_cnt=%0d, want 0/1/0", sat_cnt, sat_out, ov_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_stall();
    test_restart();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
